// File: rtl/fsub_pipe.sv
// Pipelined binary32 subtractor res = a - b, computed as a + {~b[31], b[30:0]}.
// Three lock-step stages (align, add/LZC, normalize/round) with valid/ready flow control.
module fsub_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic        ovf
);

    // Right-align the smaller significand into 24+GRS bits; every bit shifted out ORs into sticky.
    function automatic logic [26:0] align(input logic [23:0] m, input logic [7:0] d);
        logic [5:0]  sh;
        logic [61:0] w;
        sh = (d > 8'd35) ? 6'd35 : d[5:0];
        w  = {m, 38'b0} >> sh;
        return {w[61:36], w[35] | (|w[34:0])};
    endfunction

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    // Normalize, round to nearest even and pack; returns {ovf, res}.
    function automatic logic [32:0] norm_round(input logic s, input logic [7:0] e,
                                               input logic [27:0] sum, input logic [4:0] lz,
                                               input logic sub);
        logic [26:0] m;
        logic [8:0]  en;
        logic [8:0]  ef;
        logic [24:0] r;
        logic [22:0] frac;
        logic        up;
        logic [32:0] out;
        m = 27'd0;
        en = 9'd0;
        if (sum[27]) begin
            m  = {sum[27:2], sum[1] | sum[0]};
            en = {1'b0, e} + 9'd1;
        end else if ({3'b0, lz} < e) begin
            m  = sum[26:0] << lz;
            en = {1'b0, e} - {4'b0, lz};
        end else begin
            m  = sum[26:0] << (e - 8'd1);
            en = 9'd0;
        end
        up = m[2] & (m[1] | m[0] | m[3]);
        r  = {1'b0, m[26:3]} + {24'b0, up};
        if (en == 9'd0) begin
            ef   = {8'b0, r[23]};
            frac = r[22:0];
        end else if (r[24]) begin
            ef   = en + 9'd1;
            frac = r[23:1];
        end else begin
            ef   = en;
            frac = r[22:0];
        end
        if (sum == 28'd0)
            out = {1'b0, sub ? 1'b0 : s, 31'b0};
        else if (ef >= 9'd255)
            out = {1'b1, s, 8'hFF, 23'b0};
        else
            out = {1'b0, s, ef[7:0], frac};
        return out;
    endfunction

    logic        vld_p0, sign_p0, sub_p0, spec_p0;
    logic [7:0]  exp_p0;
    logic [23:0] big_p0;
    logic [26:0] small_p0;
    logic [31:0] sres_p0;
    logic        vld_p1, sign_p1, sub_p1, spec_p1;
    logic [7:0]  exp_p1;
    logic [27:0] sum_p1;
    logic [4:0]  lz_p1;
    logic [31:0] sres_p1;
    logic        vld_p2, ovf_p2;
    logic [31:0] res_p2;
    logic        advance;

    assign advance   = !vld_p2 || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_p2;
    assign res       = res_p2;
    assign ovf       = ovf_p2;

    // S1: classify, order by magnitude, align
    logic        sa, sb, a_nan, b_nan, a_inf, b_inf, a_ge;
    logic [7:0]  eea, eeb, dexp;
    logic [23:0] ma, mb;
    logic [31:0] sres;

    assign sa    = a[31];
    assign sb    = ~b[31];
    assign ma    = {a[30:23] != 8'd0, a[22:0]};
    assign mb    = {b[30:23] != 8'd0, b[22:0]};
    assign eea   = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    assign eeb   = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    assign a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    assign a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    assign a_ge  = {eea, ma} >= {eeb, mb};
    assign dexp  = a_ge ? (eea - eeb) : (eeb - eea);

    always_comb begin
        sres = {sb, b[30:0]};
        if (b_nan)
            sres = {sb, 9'h1FF, b[21:0]};
        else if (a_nan)
            sres = {sa, 9'h1FF, a[21:0]};
        else if (a_inf && b_inf && (sa != sb))
            sres = 32'hFFC00000;
        else if (a_inf)
            sres = a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            sign_p0  <= 1'b0;
            sub_p0   <= 1'b0;
            spec_p0  <= 1'b0;
            exp_p0   <= 8'd0;
            big_p0   <= 24'd0;
            small_p0 <= 27'd0;
            sres_p0  <= 32'd0;
        end else if (advance) begin
            vld_p0   <= in_valid;
            sign_p0  <= a_ge ? sa : sb;
            sub_p0   <= sa ^ sb;
            spec_p0  <= (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
            exp_p0   <= a_ge ? eea : eeb;
            big_p0   <= a_ge ? ma : mb;
            small_p0 <= align(a_ge ? mb : ma, dexp);
            sres_p0  <= sres;
        end
    end

    // S2: magnitude add/subtract and leading-zero count
    logic [27:0] sum;
    assign sum = sub_p0 ? ({1'b0, big_p0, 3'b0} - {1'b0, small_p0})
                        : ({1'b0, big_p0, 3'b0} + {1'b0, small_p0});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            sign_p1 <= 1'b0;
            sub_p1  <= 1'b0;
            spec_p1 <= 1'b0;
            exp_p1  <= 8'd0;
            sum_p1  <= 28'd0;
            lz_p1   <= 5'd0;
            sres_p1 <= 32'd0;
        end else if (advance) begin
            vld_p1  <= vld_p0;
            sign_p1 <= sign_p0;
            sub_p1  <= sub_p0;
            spec_p1 <= spec_p0;
            exp_p1  <= exp_p0;
            sum_p1  <= sum;
            lz_p1   <= lzc27(sum[26:0]);
            sres_p1 <= sres_p0;
        end
    end

    // S3: normalize, round, pack, special select
    logic [32:0] nr;
    assign nr = norm_round(sign_p1, exp_p1, sum_p1, lz_p1, sub_p1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            ovf_p2 <= 1'b0;
            res_p2 <= 32'd0;
        end else if (advance) begin
            vld_p2 <= vld_p1;
            ovf_p2 <= vld_p1 & ~spec_p1 & nr[32];
            res_p2 <= spec_p1 ? sres_p1 : nr[31:0];
        end
    end

endmodule

// File: tb/tb_fsub_pipe.sv
// Self-checking bench for fsub_pipe: directed cases plus random operands against an
// exact big-integer reference, with a lock-step occupancy model of the 3-deep pipeline.
module tb_fsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        ovf;

    fsub_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int n_in = 0;
    int n_out = 0;

    logic        mv[3];
    logic [32:0] md[3];
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [32:0] qe[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res = 32'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Exact reference: operands become integers in units of 2^-149, summed, then rounded RNE.
    function automatic logic [32:0] ref_fsub(input logic [31:0] x, input logic [31:0] y);
        logic         sx, sy, s;
        logic [7:0]   ex, ey;
        logic [22:0]  fx, fy;
        logic [299:0] vx, vy, mag, tmp, rem, half;
        logic [24:0]  keep;
        logic [31:0]  r;
        int           p, sh, e;
        sx = x[31]; sy = ~y[31];
        ex = x[30:23]; ey = y[30:23];
        fx = x[22:0]; fy = y[22:0];
        if (ex == 8'hFF || ey == 8'hFF) begin
            if (ey == 8'hFF && fy != 0)       r = {sy, 9'h1FF, y[21:0]};
            else if (ex == 8'hFF && fx != 0)  r = {sx, 9'h1FF, x[21:0]};
            else if (ex == 8'hFF && ey == 8'hFF && sx != sy) r = 32'hFFC00000;
            else if (ex == 8'hFF)             r = x;
            else                              r = {sy, y[30:0]};
            return {1'b0, r};
        end
        vx = 300'({ex != 8'd0, fx}) << ((ex == 8'd0) ? 0 : int'(ex) - 1);
        vy = 300'({ey != 8'd0, fy}) << ((ey == 8'd0) ? 0 : int'(ey) - 1);
        if (sx == sy) begin mag = vx + vy; s = sx; end
        else if (vx >= vy) begin mag = vx - vy; s = sx; end
        else begin mag = vy - vx; s = sy; end
        if (mag == 300'd0) return (sx == sy) ? {1'b0, sx, 31'b0} : 33'd0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p <= 23) return {1'b0, s, mag[30:0]};
        sh   = p - 23;
        tmp  = mag >> sh;
        keep = tmp[24:0];
        rem  = mag & ((300'd1 << sh) - 300'd1);
        half = 300'd1 << (sh - 1);
        if (rem > half || (rem == half && keep[0])) keep = keep + 25'd1;
        if (keep[24]) begin keep = keep >> 1; sh++; end
        e = sh + 1;
        if (e >= 255) return {1'b1, s, 8'hFF, 23'b0};
        return {1'b0, s, 8'(e), keep[22:0]};
    endfunction

    // One clock: compare outputs against the occupancy model, then advance it at the edge.
    task automatic cycle(input logic [32:0] exp_in, output logic acc);
        logic adv;
        #1;
        check("out_valid", 64'(out_valid), 64'(mv[2]));
        check("in_ready", 64'(in_ready), 64'(!mv[2] || out_ready));
        if (mv[2]) begin
            check("res", 64'(res), 64'(md[2][31:0]));
            check("ovf", 64'(ovf), 64'(md[2][32]));
        end else begin
            check("ovf_idle", 64'(ovf), 64'd0);
        end
        if (prev_stall) check("res_stable", 64'(res), 64'(prev_res));
        prev_stall = mv[2] && !out_ready;
        prev_res   = res;
        if (out_valid && out_ready) n_out++;
        adv = !mv[2] || out_ready;
        acc = in_valid && adv;
        if (acc) n_in++;
        if (adv) begin
            mv[2] = mv[1]; md[2] = md[1];
            mv[1] = mv[0]; md[1] = md[0];
            mv[0] = in_valid; md[0] = exp_in;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cycle(input logic ordy);
        logic [32:0] e;
        logic        acc;
        out_ready = ordy;
        if (qa.size() > 0) begin
            in_valid = 1'b1; a = qa[0]; b = qb[0]; e = qe[0];
        end else begin
            in_valid = 1'b0; a = $urandom; b = $urandom; e = 33'd0;
        end
        cycle(e, acc);
        if (acc) begin
            void'(qa.pop_front()); void'(qb.pop_front()); void'(qe.pop_front());
        end
    endtask

    task automatic push(input logic [31:0] x, input logic [31:0] y, input logic [32:0] e);
        qa.push_back(x); qb.push_back(y); qe.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (qa.size() > 0 || mv[0] || mv[1] || mv[2]); i++)
            drive_cycle(1'b1);
        check("count", 64'(n_out), 64'(n_in));
    endtask

    logic [31:0] x, y;
    logic [7:0]  t;

    initial begin
        for (int i = 0; i < 3; i++) begin mv[i] = 1'b0; md[i] = 33'd0; end
        rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0; out_ready = 1'b1;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_res", 64'(res), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single op, latency seen through the occupancy model.
        push(32'h40400000, 32'h3F800000, {1'b0, 32'h40000000});
        drain();

        // Cancellation, rounding, overflow, specials, denormals, signed zeros.
        push(32'h3F800000, 32'h3F800000, {1'b0, 32'h00000000});
        push(32'h3F800000, 32'h33000000, {1'b0, 32'h3F800000});
        push(32'h3F800000, 32'h33800000, {1'b0, 32'h3F7FFFFF});
        push(32'h7F7FFFFF, 32'hFF7FFFFF, {1'b1, 32'h7F800000});
        push(32'h7F800000, 32'h7F800000, {1'b0, 32'hFFC00000});
        push(32'h7FA00001, 32'h3F800000, {1'b0, 32'h7FE00001});
        push(32'h3F800000, 32'h7F800001, {1'b0, 32'hFFC00001});
        push(32'h3F800000, 32'h7F800000, {1'b0, 32'hFF800000});
        push(32'h00000002, 32'h00000001, {1'b0, 32'h00000001});
        push(32'h00800000, 32'h00000001, {1'b0, 32'h007FFFFF});
        push(32'h00000000, 32'h00000000, {1'b0, 32'h00000000});
        push(32'h80000000, 32'h80000000, {1'b0, 32'h00000000});
        push(32'h80000000, 32'h00000000, {1'b0, 32'h80000000});
        push(32'h007FFFFF, 32'h80000001, {1'b0, 32'h00800000});
        drain();

        // Backpressure: four ops, consumer stalled for six cycles.
        push(32'h40400000, 32'h3F800000, {1'b0, 32'h40000000});
        push(32'h40000000, 32'hBF800000, {1'b0, 32'h40400000});
        push(32'h3F800000, 32'h40000000, {1'b0, 32'hBF800000});
        push(32'h41200000, 32'h40A00000, {1'b0, 32'h40A00000});
        for (int i = 0; i < 6; i++) drive_cycle(1'b0);
        drain();

        // Reset with three ops in flight.
        push(32'h40400000, 32'h3F800000, {1'b0, 32'h40000000});
        push(32'h40000000, 32'h3F800000, {1'b0, 32'h3F800000});
        push(32'h41000000, 32'h3F800000, {1'b0, 32'h40E00000});
        for (int i = 0; i < 3; i++) drive_cycle(1'b1);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_res", 64'(res), 64'd0);
        check("midrst_ovf", 64'(ovf), 64'd0);
        for (int i = 0; i < 3; i++) begin mv[i] = 1'b0; md[i] = 33'd0; end
        prev_stall = 1'b0;
        n_in = 0; n_out = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) drive_cycle(1'b1);
        push(32'h40A00000, 32'h40000000, {1'b0, 32'h40400000});
        drain();

        // Random operands with random consumer stalls.
        for (int i = 0; i < 400; i++) begin
            x = $urandom;
            case ($urandom_range(0, 5))
                0: y = $urandom;
                1: begin
                    t = x[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
                    y = {1'($urandom), t, 23'($urandom)};
                end
                2: y = {x[31] ^ 1'($urandom), x[30:0]};
                3: begin
                    x = {x[31], 8'd0, x[22:0]};
                    y = {1'($urandom), 8'($urandom_range(0, 1)), 23'($urandom)};
                end
                4: begin
                    x = {x[31], 8'd254, x[22:0]};
                    y = {1'($urandom), 8'($urandom_range(250, 254)), 23'($urandom)};
                end
                default: y = {1'($urandom), 8'hFF, ($urandom_range(0, 1) == 1) ? 23'($urandom) : 23'd0};
            endcase
            push(x, y, ref_fsub(x, y));
        end
        for (int i = 0; i < 3000 && qa.size() > 0; i++) drive_cycle($urandom_range(0, 3) != 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
